// File: rtl/ifu_if.sv
// Fetch-side bundle of the instruction fetch unit: memory request/response channel,
// redirect input and the instruction handshake toward decode.
interface ifu_if #(
    parameter int XLEN        = 64,
    parameter int INSTR_WIDTH = 32
);
    logic                   ifu_req_valid_o;
    logic [XLEN-1:0]        ifu_req_addr_o;
    logic                   imem_req_ready_i;
    logic                   imem_rsp_valid_i;
    logic [INSTR_WIDTH-1:0] imem_rsp_instr_i;
    logic                   imem_rsp_err_i;
    logic                   redirect_valid_i;
    logic [XLEN-1:0]        redirect_pc_i;
    logic                   ifu_instr_valid_o;
    logic [INSTR_WIDTH-1:0] ifu_instr_o;
    logic [XLEN-1:0]        ifu_pc_o;
    logic                   ifu_fetch_err_o;
    logic                   id_ready_i;

    modport master (
        output ifu_req_valid_o, ifu_req_addr_o,
        output ifu_instr_valid_o, ifu_instr_o, ifu_pc_o, ifu_fetch_err_o,
        input  imem_req_ready_i, imem_rsp_valid_i, imem_rsp_instr_i, imem_rsp_err_i,
        input  redirect_valid_i, redirect_pc_i, id_ready_i
    );

    modport slave (
        input  ifu_req_valid_o, ifu_req_addr_o,
        input  ifu_instr_valid_o, ifu_instr_o, ifu_pc_o, ifu_fetch_err_o,
        output imem_req_ready_i, imem_rsp_valid_i, imem_rsp_instr_i, imem_rsp_err_i,
        output redirect_valid_i, redirect_pc_i, id_ready_i
    );
endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, issues in-order fetches under a 2-credit limit,
// buffers responses in a 2-entry FIFO toward decode and discards stale responses after redirects.
module ifu #(
    parameter int              XLEN        = 64,
    parameter int              INSTR_WIDTH = 32,
    parameter logic [XLEN-1:0] RESET_PC    = 64'h0000_0000_8000_0000
) (
    input logic   clk_i,
    input logic   rst_i,
    ifu_if.master bus
);
    typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    state_t                 state_q, state_d;
    logic [XLEN-1:0]        pc_q, pc_d;
    logic [1:0]             live_q, live_d;
    logic [1:0]             kill_q, kill_d;
    logic [1:0]             count_q, count_d;
    logic                   rd_q, rd_d, wr_q, wr_d;
    logic                   pcf_rd_q, pcf_rd_d, pcf_wr_q, pcf_wr_d;

    logic [XLEN-1:0]        ent_pc    [2];
    logic [INSTR_WIDTH-1:0] ent_instr [2];
    logic                   ent_err   [2];
    logic [XLEN-1:0]        pcf       [2];

    logic [2:0]             credit_used;
    logic                   req_hs, enq, deq, rsp_drop;

    // Every outstanding request, kept or killed, plus every buffered entry holds a credit
    assign credit_used = {1'b0, live_q} + {1'b0, kill_q} + {1'b0, count_q};

    assign bus.ifu_req_valid_o = !rst_i && (state_q != HALT) && !bus.redirect_valid_i
                                 && (credit_used < 3'd2);
    assign bus.ifu_req_addr_o  = pc_q;

    assign req_hs   = bus.ifu_req_valid_o && bus.imem_req_ready_i;
    assign rsp_drop = bus.imem_rsp_valid_i && (kill_q != 2'd0);
    assign enq      = bus.imem_rsp_valid_i && (kill_q == 2'd0) && !bus.redirect_valid_i;
    assign deq      = (count_q != 2'd0) && bus.id_ready_i;

    assign bus.ifu_instr_valid_o = (count_q != 2'd0);
    assign bus.ifu_instr_o       = (count_q != 2'd0) ? ent_instr[rd_q] : '0;
    assign bus.ifu_pc_o          = (count_q != 2'd0) ? ent_pc[rd_q]    : '0;
    assign bus.ifu_fetch_err_o   = (count_q != 2'd0) && ent_err[rd_q];

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        live_d   = live_q;
        kill_d   = kill_q;
        count_d  = count_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        pcf_rd_d = pcf_rd_q;
        pcf_wr_d = pcf_wr_q;

        if (bus.redirect_valid_i) begin
            // A response arriving alongside a redirect is always one of the now-stale requests
            pc_d     = {bus.redirect_pc_i[XLEN-1:2], 2'b00};
            kill_d   = kill_q + live_q - {1'b0, bus.imem_rsp_valid_i};
            live_d   = 2'd0;
            count_d  = 2'd0;
            rd_d     = 1'b0;
            wr_d     = 1'b0;
            pcf_rd_d = 1'b0;
            pcf_wr_d = 1'b0;
            state_d  = (kill_d != 2'd0) ? DRAIN : RUN;
        end else begin
            if (req_hs) begin
                pc_d     = pc_q + PC_STEP;
                pcf_wr_d = ~pcf_wr_q;
            end
            if (enq) begin
                wr_d     = ~wr_q;
                pcf_rd_d = ~pcf_rd_q;
            end
            if (deq) begin
                rd_d = ~rd_q;
            end
            count_d = count_q + {1'b0, enq} - {1'b0, deq};
            live_d  = live_q + {1'b0, req_hs} - {1'b0, enq};
            if (rsp_drop) begin
                kill_d = kill_q - 2'd1;
            end
            if (enq && bus.imem_rsp_err_i) begin
                // Everything fetched past a faulting instruction is wrong-path until redirected
                kill_d   = kill_q + live_d;
                live_d   = 2'd0;
                pcf_rd_d = 1'b0;
                pcf_wr_d = 1'b0;
                state_d  = HALT;
            end else if (state_q == DRAIN && kill_d == 2'd0) begin
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= RUN;
            pc_q     <= RESET_PC;
            live_q   <= 2'd0;
            kill_q   <= 2'd0;
            count_q  <= 2'd0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            pcf_rd_q <= 1'b0;
            pcf_wr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            live_q   <= live_d;
            kill_q   <= kill_d;
            count_q  <= count_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            pcf_rd_q <= pcf_rd_d;
            pcf_wr_q <= pcf_wr_d;
        end
    end

    // Payload storage needs no reset: occupancy is tracked by count_q and the pointers
    always_ff @(posedge clk_i) begin
        if (req_hs) begin
            pcf[pcf_wr_q] <= pc_q;
        end
        if (enq) begin
            ent_pc[wr_q]    <= pcf[pcf_rd_q];
            ent_instr[wr_q] <= bus.imem_rsp_instr_i;
            ent_err[wr_q]   <= bus.imem_rsp_err_i;
        end
    end
endmodule

// File: tb/tb_ifu.sv
// Scoreboard bench for ifu: a memory model checks request addresses, a monitor checks
// every instruction handed to decode against expectations queued by the stimulus.
`timescale 1ns/100ps
module tb_ifu;
    localparam int XLEN = 64;
    localparam int IW   = 32;

    typedef struct {
        int          due;
        logic [63:0] addr;
    } rsp_t;

    typedef struct {
        logic [63:0] pc;
        logic        err;
    } dlv_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ifu_if #(.XLEN(XLEN), .INSTR_WIDTH(IW)) bus ();
    ifu_if #(.XLEN(XLEN), .INSTR_WIDTH(IW)) wbus ();

    ifu #(.XLEN(XLEN), .INSTR_WIDTH(IW), .RESET_PC(64'h0000_0000_8000_0000)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    ifu #(.XLEN(XLEN), .INSTR_WIDTH(IW), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (wbus)
    );

    int          checks   = 0;
    int          errors   = 0;
    int          budget   = 0;
    int          lat      = 1;
    int          mem_cyc  = 0;
    int          last_due = 0;
    logic [63:0] err_addr = '1;

    rsp_t        rsp_q[$];
    logic [63:0] exp_req_q[$];
    dlv_t        exp_dlv_q[$];
    rsp_t        mem_r;
    dlv_t        mon_d;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return {a[21:2], 12'h013};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic redir, input logic [63:0] rpc, input logic idr);
        bus.redirect_valid_i = redir;
        bus.redirect_pc_i    = rpc;
        bus.id_ready_i       = idr;
    endtask

    task automatic expect_fetch(input logic [63:0] a);
        exp_req_q.push_back(a);
    endtask

    task automatic expect_dlv(input logic [63:0] pc, input logic err);
        dlv_t d;
        d.pc  = pc;
        d.err = err;
        exp_dlv_q.push_back(d);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_req_q.size() != 0 || exp_dlv_q.size() != 0 || rsp_q.size() != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        checkOutput({name, "_reqs_left"}, 64'(exp_req_q.size()), 64'd0);
        checkOutput({name, "_dlvs_left"}, 64'(exp_dlv_q.size()), 64'd0);
    endtask

    // Memory model: one response per cycle, in order, lat cycles after acceptance at the earliest
    initial begin
        bus.imem_req_ready_i = 1'b0;
        bus.imem_rsp_valid_i = 1'b0;
        bus.imem_rsp_instr_i = '0;
        bus.imem_rsp_err_i   = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            mem_cyc++;
            if (rst) begin
                rsp_q.delete();
            end
            if (rsp_q.size() != 0 && rsp_q[0].due <= mem_cyc) begin
                mem_r = rsp_q.pop_front();
                bus.imem_rsp_valid_i = 1'b1;
                bus.imem_rsp_instr_i = mem_word(mem_r.addr);
                bus.imem_rsp_err_i   = (mem_r.addr == err_addr);
            end else begin
                bus.imem_rsp_valid_i = 1'b0;
                bus.imem_rsp_instr_i = '0;
                bus.imem_rsp_err_i   = 1'b0;
            end
            bus.imem_req_ready_i = (budget > 0);
            #1;
            if (!rst && bus.ifu_req_valid_o && bus.imem_req_ready_i) begin
                budget--;
                if (exp_req_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_req: got %h expected none", bus.ifu_req_addr_o);
                end else begin
                    checkOutput("req_addr", bus.ifu_req_addr_o, exp_req_q.pop_front());
                end
                mem_r.due  = (mem_cyc + lat > last_due + 1) ? mem_cyc + lat : last_due + 1;
                mem_r.addr = bus.ifu_req_addr_o;
                last_due   = mem_r.due;
                rsp_q.push_back(mem_r);
            end
        end
    end

    // Monitor: every instruction consumed by decode must match the head of the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (!rst && bus.ifu_instr_valid_o && bus.id_ready_i) begin
                if (exp_dlv_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_dlv: got pc %h expected none", bus.ifu_pc_o);
                end else begin
                    mon_d = exp_dlv_q.pop_front();
                    checkOutput("dlv_pc", bus.ifu_pc_o, mon_d.pc);
                    checkOutput("dlv_instr", 64'(bus.ifu_instr_o), 64'(mem_word(mon_d.pc)));
                    checkOutput("dlv_err", 64'(bus.ifu_fetch_err_o), 64'(mon_d.err));
                end
            end
        end
    end

    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 64'h0, 1'b1);
        wbus.imem_req_ready_i = 1'b1;
        wbus.imem_rsp_valid_i = 1'b0;
        wbus.imem_rsp_instr_i = '0;
        wbus.imem_rsp_err_i   = 1'b0;
        wbus.redirect_valid_i = 1'b0;
        wbus.redirect_pc_i    = '0;
        wbus.id_ready_i       = 1'b1;

        repeat (3) @(negedge clk);
        #3;
        checkOutput("rst_req_valid", 64'(bus.ifu_req_valid_o), 64'd0);
        checkOutput("rst_instr_valid", 64'(bus.ifu_instr_valid_o), 64'd0);
        checkOutput("rst_instr", 64'(bus.ifu_instr_o), 64'd0);
        checkOutput("rst_pc", bus.ifu_pc_o, 64'd0);
        checkOutput("rst_err", 64'(bus.ifu_fetch_err_o), 64'd0);
        checkOutput("rst_wrap_req_valid", 64'(wbus.ifu_req_valid_o), 64'd0);

        $display("[TB] reset fetch");
        budget = 4;
        lat    = 1;
        for (int i = 0; i < 4; i++) begin
            expect_fetch(64'h8000_0000 + 64'(4 * i));
            expect_dlv(64'h8000_0000 + 64'(4 * i), 1'b0);
        end
        @(negedge clk);
        rst = 1'b0;
        #3;
        checkOutput("c0_req_valid", 64'(bus.ifu_req_valid_o), 64'd1);
        checkOutput("c0_req_addr", bus.ifu_req_addr_o, 64'h8000_0000);
        checkOutput("c0_instr_valid", 64'(bus.ifu_instr_valid_o), 64'd0);
        checkOutput("wrap_c0_req_valid", 64'(wbus.ifu_req_valid_o), 64'd1);
        checkOutput("wrap_c0_req_addr", wbus.ifu_req_addr_o, 64'hFFFF_FFFF_FFFF_FFFC);
        @(negedge clk);
        #3;
        checkOutput("c1_instr_valid", 64'(bus.ifu_instr_valid_o), 64'd0);
        checkOutput("wrap_c1_req_valid", 64'(wbus.ifu_req_valid_o), 64'd1);
        checkOutput("wrap_c1_req_addr", wbus.ifu_req_addr_o, 64'h0);
        @(negedge clk);
        #3;
        checkOutput("c2_instr_valid", 64'(bus.ifu_instr_valid_o), 64'd1);
        checkOutput("c2_pc", bus.ifu_pc_o, 64'h8000_0000);
        checkOutput("c2_req_valid_credit", 64'(bus.ifu_req_valid_o), 64'd0);
        wait_drain("reset_fetch");

        $display("[TB] backpressure");
        applyStimulus(1'b0, 64'h0, 1'b0);
        budget = 4;
        for (int i = 0; i < 4; i++) begin
            expect_fetch(64'h8000_0010 + 64'(4 * i));
            expect_dlv(64'h8000_0010 + 64'(4 * i), 1'b0);
        end
        repeat (6) @(negedge clk);
        #3;
        checkOutput("bp_req_valid", 64'(bus.ifu_req_valid_o), 64'd0);
        checkOutput("bp_instr_valid", 64'(bus.ifu_instr_valid_o), 64'd1);
        checkOutput("bp_head_pc", bus.ifu_pc_o, 64'h8000_0010);
        checkOutput("bp_issued", 64'(4 - budget), 64'd2);
        @(negedge clk);
        applyStimulus(1'b0, 64'h0, 1'b1);
        wait_drain("backpressure");

        $display("[TB] redirect with two outstanding");
        budget = 4;
        lat    = 3;
        expect_fetch(64'h8000_0020);
        expect_fetch(64'h8000_0024);
        expect_fetch(64'h8000_0100);
        expect_fetch(64'h8000_0104);
        expect_dlv(64'h8000_0100, 1'b0);
        expect_dlv(64'h8000_0104, 1'b0);
        repeat (2) @(negedge clk);
        applyStimulus(1'b1, 64'h8000_0102, 1'b1);
        #3;
        checkOutput("redir_req_valid", 64'(bus.ifu_req_valid_o), 64'd0);
        @(negedge clk);
        applyStimulus(1'b0, 64'h0, 1'b1);
        wait_drain("redirect_two");
        lat = 1;

        $display("[TB] redirect with response and dequeue");
        budget = 4;
        expect_fetch(64'h8000_0108);
        expect_fetch(64'h8000_010C);
        expect_fetch(64'h8000_0300);
        expect_fetch(64'h8000_0304);
        expect_dlv(64'h8000_0108, 1'b0);
        expect_dlv(64'h8000_0300, 1'b0);
        expect_dlv(64'h8000_0304, 1'b0);
        repeat (2) @(negedge clk);
        applyStimulus(1'b1, 64'h8000_0300, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 64'h0, 1'b1);
        #3;
        checkOutput("conc_instr_valid", 64'(bus.ifu_instr_valid_o), 64'd0);
        checkOutput("conc_req_valid", 64'(bus.ifu_req_valid_o), 64'd1);
        checkOutput("conc_req_addr", bus.ifu_req_addr_o, 64'h8000_0300);
        repeat (2) @(negedge clk);
        #3;
        checkOutput("conc_first_valid", 64'(bus.ifu_instr_valid_o), 64'd1);
        checkOutput("conc_first_pc", bus.ifu_pc_o, 64'h8000_0300);
        wait_drain("redirect_conc");

        $display("[TB] fetch error");
        budget   = 5;
        lat      = 1;
        err_addr = 64'h8000_030C;
        expect_fetch(64'h8000_0308);
        expect_fetch(64'h8000_030C);
        expect_fetch(64'h8000_0310);
        expect_fetch(64'h8000_0200);
        expect_fetch(64'h8000_0204);
        expect_dlv(64'h8000_0308, 1'b0);
        expect_dlv(64'h8000_030C, 1'b1);
        expect_dlv(64'h8000_0200, 1'b0);
        expect_dlv(64'h8000_0204, 1'b0);
        @(negedge clk);
        lat = 3;
        repeat (4) @(negedge clk);
        #3;
        checkOutput("err_halt_req_valid", 64'(bus.ifu_req_valid_o), 64'd0);
        checkOutput("err_head_valid", 64'(bus.ifu_instr_valid_o), 64'd1);
        checkOutput("err_head_flag", 64'(bus.ifu_fetch_err_o), 64'd1);
        checkOutput("err_head_pc", bus.ifu_pc_o, 64'h8000_030C);
        repeat (2) @(negedge clk);
        #3;
        checkOutput("err_drop_req_valid", 64'(bus.ifu_req_valid_o), 64'd0);
        checkOutput("err_drop_instr_valid", 64'(bus.ifu_instr_valid_o), 64'd0);
        @(negedge clk);
        lat = 1;
        applyStimulus(1'b1, 64'h8000_0200, 1'b1);
        #3;
        checkOutput("err_redir_req_valid", 64'(bus.ifu_req_valid_o), 64'd0);
        @(negedge clk);
        applyStimulus(1'b0, 64'h0, 1'b1);
        #3;
        checkOutput("err_resume_req_valid", 64'(bus.ifu_req_valid_o), 64'd1);
        checkOutput("err_resume_addr", bus.ifu_req_addr_o, 64'h8000_0200);
        wait_drain("fetch_error");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
